fb_arbiter: RTL and testbench

Shares the single-port 320x240, 3-bit-per-pixel framebuffer RAM between the game-logic requester and the video scanout path. Scanout reads are prefetched into a small FIFO so the display never starves; game-logic accesses are granted whenever scanout is not urgent. Sits between `game_logic`, the VGA timing block and the framebuffer RAM.

---
 rtl/tron_types_pkg.sv | 18 +
 rtl/fb_prefetch_fifo.sv | 58 +++++
 rtl/fb_arbiter.sv | 129 ++++++++++++
 tb/tb_fb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_types_pkg.sv
// Shared types for the Tron framebuffer path: screen geometry, pixel colour
// and the framebuffer arbiter's owner encoding.
package tron_types;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   typedef logic [2:0] Color;

   typedef enum logic [1:0] {
      IDLE,
      SCAN_URGENT,
      GAME,
      SCAN_FILL
   } ArbOwner;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Scanout prefetch FIFO: first-word-fall-through head with a same-cycle
// bypass, so a pixel returning from RAM is visible at the head immediately.
module fb_prefetch_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         pop,
   output logic [DATA_W-1:0]            head,
   output logic                         head_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              stored;
   logic              pop_ok;
   logic              write_en;
   logic              read_en;

   assign stored     = (count != '0);
   assign head_valid = stored || push;
   assign head       = stored ? mem[rd_ptr] : (push ? push_data : '0);
   assign pop_ok     = pop && head_valid;

   // A push into an empty FIFO that is popped the same cycle passes straight through.
   assign write_en = push && !(pop_ok && !stored);
   assign read_en  = pop_ok && stored;

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (read_en)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(write_en) - CNT_W'(read_en);
      end
   end

   // NOTE: storage is deliberately not reset; the count gates every read, so
   // stale entries are never visible and the array can map to plain RAM.
   always_ff @(posedge clock) begin
      if (write_en && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port RAM between game logic and
// a prefetching scanout path that is guaranteed priority when nearly starved.
module fb_arbiter #(
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 3,
   parameter int FB_PIXELS = tron_types::FB_PIXELS,
   parameter int DEPTH     = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_address,
   input  logic [DATA_W-1:0] game_write_data,
   output logic              game_grant,
   output logic              game_read_valid,
   output logic [DATA_W-1:0] game_read_data,
   input  logic              scan_start_frame,
   input  logic              scan_pop,
   output logic [DATA_W-1:0] scan_pixel,
   output logic              scan_valid,
   output logic              scan_underflow,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_write_enabled,
   output logic [DATA_W-1:0] ram_write_data,
   input  logic [DATA_W-1:0] ram_read_data
);

   import tron_types::*;

   localparam int                CNT_W        = $clog2(DEPTH+1);
   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FB_PIXELS - 1);
   localparam logic [CNT_W:0]    URGENT_LEVEL = (CNT_W+1)'(2);
   localparam logic [CNT_W:0]    FILL_LEVEL   = (CNT_W+1)'(DEPTH);

   logic [ADDR_W-1:0] scan_addr;
   logic              frame_active;
   logic              scan_in_flight;
   logic [DATA_W-1:0] read_hold;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occ;
   logic              scan_eligible;
   logic              scan_issue;
   logic              fifo_push;
   ArbOwner           owner;

   assign occ = {1'b0, fifo_count} + (CNT_W+1)'(scan_in_flight);

   // A read issued on the restart cycle would return stale pre-restart data.
   assign scan_eligible = frame_active && !scan_start_frame;

   always_comb begin
      // NOTE: default first so every path assigns owner and no latch is inferred.
      owner = IDLE;
      if (reset)
         owner = IDLE;
      else if (scan_eligible && occ < URGENT_LEVEL)
         owner = SCAN_URGENT;
      else if (game_req)
         owner = GAME;
      else if (scan_eligible && occ < FILL_LEVEL)
         owner = SCAN_FILL;
   end

   assign scan_issue = (owner == SCAN_URGENT) || (owner == SCAN_FILL);

   always_comb begin
      ram_address       = '0;
      ram_write_enabled = 1'b0;
      ram_write_data    = '0;
      game_grant        = 1'b0;
      case (owner)
         SCAN_URGENT, SCAN_FILL: ram_address = scan_addr;
         GAME: begin
            game_grant        = 1'b1;
            ram_address       = game_address;
            ram_write_enabled = game_we;
            ram_write_data    = game_write_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         scan_addr       <= '0;
         frame_active    <= 1'b0;
         scan_in_flight  <= 1'b0;
         game_read_valid <= 1'b0;
         read_hold       <= '0;
         scan_underflow  <= 1'b0;
      end else begin
         scan_in_flight  <= scan_issue;
         game_read_valid <= game_grant && !game_we;
         if (game_read_valid) read_hold <= ram_read_data;

         if (scan_start_frame) begin
            scan_addr    <= '0;
            frame_active <= 1'b1;
         end else if (scan_issue) begin
            // The last pixel ends the frame; the address parks until restart.
            if (scan_addr == LAST_ADDR) frame_active <= 1'b0;
            else                        scan_addr    <= scan_addr + ADDR_W'(1);
         end

         if (scan_start_frame)            scan_underflow <= 1'b0;
         else if (scan_pop && !scan_valid) scan_underflow <= 1'b1;
      end
   end

   assign game_read_data = game_read_valid ? ram_read_data : read_hold;
   assign fifo_push      = scan_in_flight && !scan_start_frame;

   fb_prefetch_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (scan_start_frame),
      .push       (fifo_push),
      .push_data  (ram_read_data),
      .pop        (scan_pop),
      .head       (scan_pixel),
      .head_valid (scan_valid),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM model.
// Frame size is shrunk so a whole frame of sustained scanout stays short.
module tb_fb_arbiter;

   localparam int ADDR_W    = 19;
   localparam int DATA_W    = 3;
   localparam int DEPTH     = 4;
   localparam int TB_PIXELS = 2000;

   logic              clock = 1'b0;
   logic              reset;
   logic              game_req;
   logic              game_we;
   logic [ADDR_W-1:0] game_address;
   logic [DATA_W-1:0] game_write_data;
   logic              game_grant;
   logic              game_read_valid;
   logic [DATA_W-1:0] game_read_data;
   logic              scan_start_frame;
   logic              scan_pop;
   logic [DATA_W-1:0] scan_pixel;
   logic              scan_valid;
   logic              scan_underflow;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_write_enabled;
   logic [DATA_W-1:0] ram_write_data;
   logic [DATA_W-1:0] ram_read_data;

   logic [DATA_W-1:0] ram [4096];
   logic [DATA_W-1:0] ram_q;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   fb_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .FB_PIXELS (TB_PIXELS),
      .DEPTH     (DEPTH)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .game_req          (game_req),
      .game_we           (game_we),
      .game_address      (game_address),
      .game_write_data   (game_write_data),
      .game_grant        (game_grant),
      .game_read_valid   (game_read_valid),
      .game_read_data    (game_read_data),
      .scan_start_frame  (scan_start_frame),
      .scan_pop          (scan_pop),
      .scan_pixel        (scan_pixel),
      .scan_valid        (scan_valid),
      .scan_underflow    (scan_underflow),
      .ram_address       (ram_address),
      .ram_write_enabled (ram_write_enabled),
      .ram_write_data    (ram_write_data),
      .ram_read_data     (ram_read_data)
   );

   always @(posedge clock) begin
      if (ram_write_enabled) ram[ram_address[11:0]] <= ram_write_data;
      ram_q <= ram[ram_address[11:0]];
   end
   assign ram_read_data = ram_q;

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      n_cmp++; if (game_grant !== 1'b0) begin n_bad++; $display("FAIL reset_grant got=%0b want=0", game_grant); end
      n_cmp++; if (game_read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid got=%0b want=0", game_read_valid); end
      n_cmp++; if (game_read_data !== 3'd0) begin n_bad++; $display("FAIL reset_read_data got=%0d want=0", game_read_data); end
      n_cmp++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL reset_scan_valid got=%0b want=0", scan_valid); end
      n_cmp++; if (scan_pixel !== 3'd0) begin n_bad++; $display("FAIL reset_scan_pixel got=%0d want=0", scan_pixel); end
      n_cmp++; if (scan_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow got=%0b want=0", scan_underflow); end
      n_cmp++; if (ram_write_enabled !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we got=%0b want=0", ram_write_enabled); end
      n_cmp++; if (ram_address !== '0) begin n_bad++; $display("FAIL reset_ram_addr got=%0d want=0", ram_address); end
      reset = 1'b0;
   endtask

   task automatic test_game_access();
      @(negedge clock);
      game_req = 1'b1; game_we = 1'b1; game_address = 1000; game_write_data = 3'b100;
      #1;
      n_cmp++; if (game_grant !== 1'b1) begin n_bad++; $display("FAIL game_wr_grant got=%0b want=1", game_grant); end
      n_cmp++; if (ram_write_enabled !== 1'b1) begin n_bad++; $display("FAIL game_wr_we got=%0b want=1", ram_write_enabled); end
      n_cmp++; if (ram_address !== 19'd1000) begin n_bad++; $display("FAIL game_wr_addr got=%0d want=1000", ram_address); end
      n_cmp++; if (ram_write_data !== 3'b100) begin n_bad++; $display("FAIL game_wr_data got=%0d want=4", ram_write_data); end
      @(negedge clock);
      game_we = 1'b0;
      #1;
      n_cmp++; if (game_grant !== 1'b1) begin n_bad++; $display("FAIL game_rd_grant got=%0b want=1", game_grant); end
      n_cmp++; if (ram_write_enabled !== 1'b0) begin n_bad++; $display("FAIL game_rd_we got=%0b want=0", ram_write_enabled); end
      @(negedge clock);
      game_req = 1'b0;
      #1;
      n_cmp++; if (game_read_valid !== 1'b1) begin n_bad++; $display("FAIL game_rd_valid got=%0b want=1", game_read_valid); end
      n_cmp++; if (game_read_data !== 3'b100) begin n_bad++; $display("FAIL game_rd_data got=%0d want=4", game_read_data); end
      // Put RAM[1000] back to its preload value (1000 % 8 = 0).
      @(negedge clock);
      game_req = 1'b1; game_we = 1'b1; game_write_data = 3'd0;
      @(negedge clock);
      game_req = 1'b0; game_we = 1'b0;
      #1;
      n_cmp++; if (game_read_valid !== 1'b0) begin n_bad++; $display("FAIL game_wr_no_valid got=%0b want=0", game_read_valid); end
   endtask

   task automatic test_fill();
      @(negedge clock);
      scan_start_frame = 1'b1;
      @(negedge clock);
      scan_start_frame = 1'b0;
      #1;
      n_cmp++; if (ram_address !== 19'd0 || game_grant !== 1'b0) begin n_bad++; $display("FAIL fill_first_addr got=%0d want=0", ram_address); end
      n_cmp++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL fill_valid_n1 got=%0b want=0", scan_valid); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock); #1;
         n_cmp++; if (ram_address !== ADDR_W'(k)) begin n_bad++; $display("FAIL fill_addr_%0d got=%0d want=%0d", k, ram_address, k); end
         if (k == 1) begin
            n_cmp++; if (scan_valid !== 1'b1) begin n_bad++; $display("FAIL fill_valid_n2 got=%0b want=1", scan_valid); end
            n_cmp++; if (scan_pixel !== 3'd0) begin n_bad++; $display("FAIL fill_pixel_n2 got=%0d want=0", scan_pixel); end
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock); #1;
         n_cmp++; if (ram_address !== '0) begin n_bad++; $display("FAIL fill_stop_%0d got=%0d want=0", k, ram_address); end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         scan_pop = 1'b1;
         #1;
         n_cmp++; if (scan_pixel !== 3'(k)) begin n_bad++; $display("FAIL fill_pop_%0d got=%0d want=%0d", k, scan_pixel, k); end
      end
      @(negedge clock);
      scan_pop = 1'b0;
   endtask

   task automatic test_urgent();
      @(negedge clock);
      scan_start_frame = 1'b1;
      @(negedge clock);
      scan_start_frame = 1'b0; game_req = 1'b1; game_we = 1'b0; game_address = 10;
      #1;
      n_cmp++; if (game_grant !== 1'b0 || ram_address !== 19'd0) begin n_bad++; $display("FAIL urgent_occ0 grant=%0b addr=%0d want grant=0 addr=0", game_grant, ram_address); end
      @(negedge clock); #1;
      n_cmp++; if (game_grant !== 1'b0 || ram_address !== 19'd1) begin n_bad++; $display("FAIL urgent_occ1 grant=%0b addr=%0d want grant=0 addr=1", game_grant, ram_address); end
      @(negedge clock); #1;
      n_cmp++; if (game_grant !== 1'b1 || ram_address !== 19'd10) begin n_bad++; $display("FAIL urgent_occ2 grant=%0b addr=%0d want grant=1 addr=10", game_grant, ram_address); end
      @(negedge clock);
      game_req = 1'b0;
      #1;
      n_cmp++; if (game_read_valid !== 1'b1 || game_read_data !== 3'd2) begin n_bad++; $display("FAIL urgent_game_read valid=%0b data=%0d want valid=1 data=2", game_read_valid, game_read_data); end
   endtask

   task automatic test_restart_discard();
      bit found = 1'b0;
      for (int i = 0; i < 1500 && !found; i++) begin
         @(negedge clock);
         scan_pop = scan_valid;
         #1;
         if (!game_grant && !ram_write_enabled && ram_address == 19'd500) found = 1'b1;
      end
      n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL restart_reach_500 got=%0b want=1", found); end
      @(negedge clock);
      scan_pop = 1'b0; scan_start_frame = 1'b1;
      @(negedge clock);
      scan_start_frame = 1'b0;
      #1;
      n_cmp++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL restart_discard_valid got=%0b want=0", scan_valid); end
      n_cmp++; if (ram_address !== 19'd0) begin n_bad++; $display("FAIL restart_addr got=%0d want=0", ram_address); end
      @(negedge clock); #1;
      n_cmp++; if (scan_valid !== 1'b1 || scan_pixel !== 3'd0) begin n_bad++; $display("FAIL restart_pixel valid=%0b pixel=%0d want valid=1 pixel=0", scan_valid, scan_pixel); end
      @(negedge clock); #1;
      n_cmp++; if (scan_pixel !== 3'd0) begin n_bad++; $display("FAIL restart_head_hold got=%0d want=0", scan_pixel); end
   endtask

   task automatic test_sustained();
      int grants = 0;
      int cycles = 0;
      int pix = 0;
      int bad_pix = 0;
      int max_addr = 0;
      @(negedge clock);
      scan_start_frame = 1'b1; game_req = 1'b1; game_we = 1'b0; game_address = 7;
      for (int c = 1; c <= 2*TB_PIXELS + 4; c++) begin
         @(negedge clock);
         scan_start_frame = 1'b0;
         scan_pop = (c % 2 == 0) && (c <= 2*TB_PIXELS);
         #1;
         cycles++;
         if (game_grant) grants++;
         if (!game_grant && !ram_write_enabled && int'(ram_address) > max_addr) max_addr = int'(ram_address);
         if (scan_pop) begin
            if (scan_valid !== 1'b1 || scan_pixel !== 3'(pix % 8)) bad_pix++;
            pix++;
         end
      end
      @(negedge clock);
      scan_pop = 1'b0;
      #1;
      n_cmp++; if (bad_pix !== 0) begin n_bad++; $display("FAIL sustain_pixels bad=%0d want=0", bad_pix); end
      n_cmp++; if (scan_underflow !== 1'b0) begin n_bad++; $display("FAIL sustain_underflow got=%0b want=0", scan_underflow); end
      n_cmp++; if (grants * 2 < cycles) begin n_bad++; $display("FAIL sustain_bandwidth grants=%0d cycles=%0d want>=half", grants, cycles); end
      n_cmp++; if (max_addr !== TB_PIXELS - 1) begin n_bad++; $display("FAIL sustain_last_addr got=%0d want=%0d", max_addr, TB_PIXELS - 1); end
      n_cmp++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL sustain_drained got=%0b want=0", scan_valid); end
   endtask

   task automatic test_idle_grant();
      int grants = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock); #1;
         if (game_grant === 1'b1 && ram_address === 19'd7) grants++;
      end
      @(negedge clock);
      game_req = 1'b0;
      n_cmp++; if (grants !== 10) begin n_bad++; $display("FAIL idle_grants got=%0d want=10", grants); end
   endtask

   task automatic test_underflow_and_reset();
      @(negedge clock);
      scan_pop = 1'b1;
      #1;
      n_cmp++; if (scan_pixel !== 3'd0 || scan_valid !== 1'b0) begin n_bad++; $display("FAIL uf_empty_head pixel=%0d valid=%0b want 0/0", scan_pixel, scan_valid); end
      @(negedge clock);
      scan_pop = 1'b0;
      #1;
      n_cmp++; if (scan_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set got=%0b want=1", scan_underflow); end
      @(negedge clock); scan_pop = 1'b1;
      @(negedge clock); scan_pop = 1'b0;
      @(negedge clock); #1;
      n_cmp++; if (scan_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got=%0b want=1", scan_underflow); end
      @(negedge clock);
      scan_start_frame = 1'b1;
      @(negedge clock);
      scan_start_frame = 1'b0;
      #1;
      n_cmp++; if (scan_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear got=%0b want=0", scan_underflow); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1; game_req = 1'b1; game_we = 1'b1; game_address = 33; game_write_data = 3'd5;
      @(negedge clock); #1;
      n_cmp++; if (game_grant !== 1'b0 || ram_write_enabled !== 1'b0 || ram_address !== '0) begin n_bad++; $display("FAIL midrst_ram grant=%0b we=%0b addr=%0d want 0/0/0", game_grant, ram_write_enabled, ram_address); end
      n_cmp++; if (scan_valid !== 1'b0 || scan_pixel !== 3'd0) begin n_bad++; $display("FAIL midrst_scan valid=%0b pixel=%0d want 0/0", scan_valid, scan_pixel); end
      n_cmp++; if (game_read_valid !== 1'b0 || game_read_data !== 3'd0 || scan_underflow !== 1'b0) begin n_bad++; $display("FAIL midrst_regs rv=%0b rd=%0d uf=%0b want 0/0/0", game_read_valid, game_read_data, scan_underflow); end
      @(negedge clock);
      reset = 1'b0; game_req = 1'b0; game_we = 1'b0;
      #1;
      n_cmp++; if (scan_valid !== 1'b0 || ram_address !== '0) begin n_bad++; $display("FAIL postrst_1 valid=%0b addr=%0d want 0/0", scan_valid, ram_address); end
      @(negedge clock); #1;
      n_cmp++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL postrst_2 valid=%0b want=0", scan_valid); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 3'(i % 8);
      reset = 1'b1; game_req = 1'b0; game_we = 1'b0; game_address = '0; game_write_data = '0;
      scan_start_frame = 1'b0; scan_pop = 1'b0;
      test_reset();
      test_game_access();
      test_fill();
      test_urgent();
      test_restart_discard();
      test_sustained();
      test_idle_grant();
      test_underflow_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
